// File: rtl/config_loader.sv
// Bitstream loader: accepts host words, shifts them LSB-first into a configuration
// scan chain and tracks a CRC-16-CCITT of the loaded bits. Optional readback: CFG_READBACK_EN.
module config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4416,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_in,
  output logic              cfg_en,
  input  logic              cfg_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int REM_W = $clog2(WORD_W + 1);

`ifdef CFG_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem_init;
  logic [CNT_W-1:0]  bits_left;
  logic [15:0]       crc;
  logic              cfg_in_q;
`ifdef CFG_READBACK_EN
  logic [15:0]       crc_rb;
  logic [CNT_W-1:0]  vcnt;
`endif

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  // Bits still to shift after the first one of the word just accepted (n-1).
  always_comb begin
    bits_left = CNT_W'(CHAIN_LEN) - bit_cnt;
    if (bits_left < CNT_W'(WORD_W)) rem_init = REM_W'(bits_left - 1'b1);
    else                            rem_init = REM_W'(WORD_W - 1);
  end

`ifdef CFG_READBACK_EN
  // Recirculation needs the chain output in the same cycle, so it bypasses the register.
  assign cfg_in = (state == S_VERIFY) ? cfg_out : cfg_in_q;
`else
  logic cfg_out_unused;
  assign cfg_out_unused = cfg_out;
  assign cfg_in         = cfg_in_q;
`endif

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state    <= S_IDLE;
      s_ready  <= 1'b0;
      cfg_in_q <= 1'b0;
      cfg_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bit_cnt  <= '0;
      word_q   <= '0;
      rem      <= '0;
      crc      <= 16'hFFFF;
`ifdef CFG_READBACK_EN
      crc_rb   <= 16'hFFFF;
      vcnt     <= '0;
`endif
    end else if (abort && state != S_IDLE) begin
      state    <= S_IDLE;
      s_ready  <= 1'b0;
      cfg_in_q <= 1'b0;
      cfg_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            bit_cnt <= '0;
            err     <= 1'b0;
            crc     <= 16'hFFFF;
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready) begin
            state    <= S_SHIFT;
            s_ready  <= 1'b0;
            cfg_en   <= 1'b1;
            cfg_in_q <= s_data[0];
            word_q   <= s_data >> 1;
            rem      <= rem_init;
            bit_cnt  <= bit_cnt + 1'b1;
            crc      <= crc_step(crc, s_data[0]);
          end
        end
        S_SHIFT: begin
          if (rem != '0) begin
            cfg_in_q <= word_q[0];
            word_q   <= word_q >> 1;
            rem      <= rem - 1'b1;
            bit_cnt  <= bit_cnt + 1'b1;
            crc      <= crc_step(crc, word_q[0]);
          end else begin
            cfg_in_q <= 1'b0;
            if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
`ifdef CFG_READBACK_EN
              state  <= S_VERIFY;
              vcnt   <= '0;
              crc_rb <= 16'hFFFF;
`else
              cfg_en <= 1'b0;
              state  <= S_DONE;
              done   <= 1'b1;
`endif
            end else begin
              cfg_en  <= 1'b0;
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end
        end
`ifdef CFG_READBACK_EN
        S_VERIFY: begin
          crc_rb <= crc_step(crc_rb, cfg_out);
          vcnt   <= vcnt + 1'b1;
          if (vcnt == CNT_W'(CHAIN_LEN - 1)) begin
            cfg_en <= 1'b0;
            state  <= S_DONE;
            done   <= 1'b1;
            err    <= (crc_step(crc_rb, cfg_out) != crc);
          end
        end
`endif
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader (WORD_W=8, CHAIN_LEN=20) with a 20-bit chain model.
`timescale 1ns/1ps
module tb_config_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
`ifdef CFG_READBACK_EN
  localparam int EXP_EN = 2 * CHAIN_LEN;
`else
  localparam int EXP_EN = CHAIN_LEN;
`endif
  // A5,3C,0F loaded LSB-first; first bit ends at the chain's far end.
  localparam logic [CHAIN_LEN-1:0] EXP_CHAIN = 20'hA53CF;
  localparam logic [CHAIN_LEN-1:0] FLIP      = 20'h00100;

  logic prog_clk = 1'b0;
  logic prog_rst_n, start, abort, s_valid, s_ready, cfg_in, cfg_en, cfg_out, busy, done, err;
  logic [WORD_W-1:0]    s_data;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 flip_req = 1'b0;

  int errors = 0, checks = 0;
  int sess_en = 0, done_cnt = 0, pushed = 0, cycle = 0;
  bit exp_q[$];
  int xfer_cyc[$];
  bit exp_bit;

  always #5 prog_clk = ~prog_clk;

  config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(cfg_out),
    .busy(busy), .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  assign cfg_out = chain[CHAIN_LEN-1];

  always @(posedge prog_clk) begin
    cycle++;
    if (cfg_en === 1'b1) chain <= {chain[CHAIN_LEN-2:0], cfg_in} ^ (flip_req ? FLIP : '0);
  end

  // Scoreboard consumer: every load-phase enable pops one expected bit.
  always @(negedge prog_clk) begin
    if (done === 1'b1) done_cnt++;
    if (cfg_en === 1'b1) begin
      sess_en++;
      if (sess_en <= CHAIN_LEN) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cfg_in_unexpected: cfg_en=1 with no expected bit at cycle %0d", cycle);
        end else begin
          exp_bit = exp_q.pop_front();
          if (cfg_in !== exp_bit) begin
            errors++;
            $display("FAIL cfg_in_bit%0d: got %b expected %b", sess_en - 1, cfg_in, exp_bit);
          end
        end
      end
    end
    if (s_ready === 1'b1) begin
      checks++;
      if (cfg_en !== 1'b0) begin
        errors++;
        $display("FAIL ready_vs_en: cfg_en=%b while s_ready=1, expected 0", cfg_en);
      end
    end
  end

  task automatic tick();
    @(posedge prog_clk); #1;
  endtask

  task automatic clear_session();
    sess_en = 0; done_cnt = 0; pushed = 0;
    exp_q.delete(); xfer_cyc.delete();
  endtask

  task automatic begin_session();
    start = 1'b1; tick(); start = 1'b0;
    clear_session();
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
    int n, g;
    bit acc;
    s_valid = 1'b0;
    if (gap > 0) begin
      g = 0;
      for (int t = 0; t < 100 && g < gap; t++) begin
        @(negedge prog_clk);
        if (s_ready === 1'b1) g++;
      end
      @(posedge prog_clk); #1;
      checks++;
      if (g < gap) begin
        errors++;
        $display("FAIL gap_wait_timeout: saw %0d ready cycles, required %0d", g, gap);
      end
    end
    s_data = w; s_valid = 1'b1;
    n = (CHAIN_LEN - pushed < WORD_W) ? CHAIN_LEN - pushed : WORD_W;
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    pushed += n;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge prog_clk); acc = (s_ready === 1'b1);
      @(posedge prog_clk); #1;
    end
    xfer_cyc.push_back(cycle);
    s_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL handshake_timeout: word %h not accepted, s_ready=%b", w, s_ready);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge prog_clk); seen = (done === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: done=0 after 300 cycles, required 1", tag);
    end
    @(posedge prog_clk); #1;
  endtask

  task automatic test_reset();
    prog_rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    checks++;
    if ({s_ready, cfg_in, cfg_en, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {s_ready, cfg_in, cfg_en, busy, done, err});
    end
    checks++;
    if (bit_cnt !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    prog_rst_n = 1'b1;
    clear_session();
    repeat (6) tick();
    checks++;
    if (sess_en != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: enables=%0d busy=%b, required 0 and 0", sess_en, busy);
    end
  endtask

  task automatic test_load(input int gap, input string tag);
    begin_session();
    send_word(8'hA5, gap); send_word(8'h3C, gap); send_word(8'h0F, gap);
    wait_done(tag);
    @(negedge prog_clk);
    checks++;
    if (done !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_pulse: pulses=%0d done=%b, required 1 pulse", tag, done_cnt, done);
    end
    checks++;
    if (sess_en != EXP_EN) begin errors++; $display("FAIL %s_enables: got %0d expected %0d", tag, sess_en, EXP_EN); end
    checks++;
    if (bit_cnt !== CNT_W'(CHAIN_LEN)) begin errors++; $display("FAIL %s_bit_cnt: got %0d expected %0d", tag, bit_cnt, CHAIN_LEN); end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_status: err=%b busy=%b, required 0 0", tag, err, busy); end
    checks++;
    if (chain !== EXP_CHAIN || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_chain: got %h (left %0d) expected %h", tag, chain, exp_q.size(), EXP_CHAIN);
    end
    if (gap == 0) begin
      checks++;
      if (xfer_cyc[1] - xfer_cyc[0] != WORD_W + 1 || xfer_cyc[2] - xfer_cyc[1] != WORD_W + 1) begin
        errors++;
        $display("FAIL %s_throughput: word spacing %0d,%0d expected %0d", tag,
                 xfer_cyc[1] - xfer_cyc[0], xfer_cyc[2] - xfer_cyc[1], WORD_W + 1);
      end
    end
    tick();
  endtask

  task automatic test_abort();
    begin_session();
    send_word(8'hA5, 0);
    repeat (4) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({cfg_en, busy, err, done} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_flags: en/busy/err/done=%b expected 0010", {cfg_en, busy, err, done});
    end
    checks++;
    if (sess_en != 5 || exp_q.size() != 3) begin
      errors++;
      $display("FAIL abort_bits: shifted %0d left %0d, expected 5 and 3", sess_en, exp_q.size());
    end
    repeat (2) tick();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    clear_session();
    checks++;
    if ({busy, s_ready, err} !== 3'b110) begin
      errors++;
      $display("FAIL start_over_abort: busy/ready/err=%b expected 110", {busy, s_ready, err});
    end
    send_word(8'hA5, 0); send_word(8'h3C, 0); send_word(8'h0F, 0);
    wait_done("reload");
    checks++;
    if (sess_en != EXP_EN || err !== 1'b0 || bit_cnt !== CNT_W'(CHAIN_LEN) || chain !== EXP_CHAIN) begin
      errors++;
      $display("FAIL reload: enables=%0d err=%b bit_cnt=%0d chain=%h, expected %0d 0 %0d %h",
               sess_en, err, bit_cnt, chain, EXP_EN, CHAIN_LEN, EXP_CHAIN);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    begin_session();
    send_word(8'hA5, 0);
    repeat (2) tick();
    #2 prog_rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, cfg_in, cfg_en, busy, done, err} !== 6'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: flags=%b bit_cnt=%0d, required all 0",
               {s_ready, cfg_in, cfg_en, busy, done, err}, bit_cnt);
    end
    tick(); prog_rst_n = 1'b1;
    clear_session();
    repeat (6) tick();
    checks++;
    if (sess_en != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: enables=%0d busy=%b, required 0 0", sess_en, busy);
    end
  endtask

  task automatic test_start_ignored();
    begin_session();
    repeat (2) tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, s_ready, cfg_en} !== 3'b110 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL start_in_load: busy/ready/en=%b bit_cnt=%0d, expected 110 and 0", {busy, s_ready, cfg_en}, bit_cnt);
    end
    send_word(8'hA5, 0); send_word(8'h3C, 0); send_word(8'h0F, 0);
    wait_done("start_ignored");
    checks++;
    if (sess_en != EXP_EN || bit_cnt !== CNT_W'(CHAIN_LEN) || chain !== EXP_CHAIN) begin
      errors++;
      $display("FAIL start_ignored_load: enables=%0d bit_cnt=%0d chain=%h, expected %0d %0d %h",
               sess_en, bit_cnt, chain, EXP_EN, CHAIN_LEN, EXP_CHAIN);
    end
    tick();
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback_flip();
    bit hit = 1'b0;
    begin_session();
    send_word(8'hA5, 0); send_word(8'h3C, 0); send_word(8'h0F, 0);
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge prog_clk); hit = (sess_en >= CHAIN_LEN + 10);
    end
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_done("flip");
    checks++;
    if (err !== 1'b1 || !hit) begin
      errors++;
      $display("FAIL readback_flip: err=%b reached_verify=%b, required 1 1", err, hit);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load(0, "contig");
    test_load(3, "gapped");
`ifdef CFG_READBACK_EN
    test_readback_flip();
`endif
    test_abort();
    test_reset_mid_shift();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
